// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM states, the IF/ID
// register layout and the canonical NOP used for bubbles.
package fetch_types;

    localparam int          FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD_WAIT
    } fetch_state_t;

    typedef struct packed {
        logic                  valid;
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } if_id_fields_t;

endpackage

// File: rtl/fetch_unit_hold_buf.sv
// Single-entry holding buffer for an instruction that returned from the
// icache while the IF/ID register could not accept it.
module fetch_hold_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    // Entry storage; clear wins over load so a flush always empties it.
    always_ff @(posedge clk) begin
        // NOTE: the data word is reset along with the flag; it is a single
        // register, so a known value costs nothing and keeps traces clean.
        if (!rst_n || clear) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, requests instructions from the icache, buffers a
// response that lands during a stall and drives the IF/ID register.
// Optional build macro FETCH_PERF_EN adds stall/redirect perf counters.
module fetch_unit
    import fetch_types::*;
#(
    parameter int               XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0060
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_pc,
    input  logic            if_id_load,
    input  logic            stall_mem,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            icache_read,
    output logic [XLEN-1:0] icache_addr,
    input  logic            icache_resp,
    input  logic [XLEN-1:0] icache_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_redirects
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] discard_addr_q, discard_addr_d;
    if_id_fields_t   if_id_q, if_id_d;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] buf_data;
    logic            buf_valid, buf_load, buf_clear;
    logic            advance, flush;

    // A memory stall freezes everything, including redirects; EX re-asserts.
    assign advance = load_pc & if_id_load & ~stall_mem;
    assign flush   = redirect & ~stall_mem;
    assign target  = redirect_pc & ~XLEN'(3);

    fetch_hold_buf #(.W(XLEN)) u_hold_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (icache_rdata),
        .dout  (buf_data),
        .valid (buf_valid)
    );

    // Next-state, next-PC, IF/ID update and icache request generation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave one unassigned (no latches).
        state_d        = state_q;
        pc_d           = pc_q;
        discard_addr_d = discard_addr_q;
        if_id_d        = if_id_q;
        buf_load       = 1'b0;
        buf_clear      = 1'b0;
        icache_read    = 1'b0;
        icache_addr    = pc_q;

        case (state_q)
            FETCH: begin
                icache_read = 1'b1;
                if (flush) begin
                    pc_d = target;
                    if (!icache_resp) begin
                        // Request still in flight: remember its address so it
                        // stays stable until the stale response is swallowed.
                        discard_addr_d = pc_q;
                        state_d        = DISCARD_WAIT;
                    end
                end else if (icache_resp) begin
                    if (advance) begin
                        if_id_d = '{valid: 1'b1, pc: pc_q, instr: icache_rdata};
                        pc_d    = pc_q + XLEN'(4);
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (advance) begin
                    if_id_d = '{valid: 1'b0, pc: if_id_q.pc, instr: NOP_INSTR};
                end
            end
            HOLD: begin
                if (flush) begin
                    buf_clear = 1'b1;
                    pc_d      = target;
                    state_d   = FETCH;
                end else if (advance) begin
                    if_id_d   = '{valid: 1'b1, pc: pc_q,
                                  instr: buf_valid ? buf_data : NOP_INSTR};
                    pc_d      = pc_q + XLEN'(4);
                    buf_clear = 1'b1;
                    state_d   = FETCH;
                end
            end
            DISCARD_WAIT: begin
                icache_read = 1'b1;
                icache_addr = discard_addr_q;
                if (flush) begin
                    pc_d = target;
                end
                if (icache_resp) begin
                    state_d = FETCH;
                end
                if (advance) begin
                    if_id_d = '{valid: 1'b0, pc: if_id_q.pc, instr: NOP_INSTR};
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // A flush kills whatever IF/ID would otherwise have captured.
        if (flush) begin
            if_id_d = '{valid: 1'b0, pc: if_id_q.pc, instr: NOP_INSTR};
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is only ever written with non-blocking
        // assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q        <= icache_read ? DISCARD_WAIT : FETCH;
            discard_addr_q <= icache_addr;
            pc_q           <= RESET_PC;
            if_id_q        <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else begin
            state_q        <= state_d;
            discard_addr_q <= discard_addr_d;
            pc_q           <= pc_d;
            if_id_q        <= if_id_d;
        end
    end

    assign if_id_valid = if_id_q.valid;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;

`ifdef FETCH_PERF_EN
    // Saturating counters for icache wait cycles and taken flushes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (icache_read && !icache_resp && perf_stall_cycles != 32'hFFFF_FFFF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush && perf_redirects != 32'hFFFF_FFFF)
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage feeding the IF/ID pipeline register that the hazard/forwarding logic reads.
- Owns the PC, issues requests to the instruction cache, and buffers a response that arrives while downstream is stalled.
- Applies stalls from the load-use hazard detector (load_pc, if_id_load) and from the data cache, and flushes on EX-resolved redirects.

Parameters:
- RESET_PC, 32'h0000_0060, PC value after reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- load_pc  in  1  from hazard detector; 0 = load-use stall
- if_id_load  in  1  from hazard detector; 0 = hold IF/ID
- stall_mem  in  1  data-cache miss; freezes whole pipeline
- redirect  in  1  taken branch/jal/jalr resolved in EX
- redirect_pc  in  XLEN  target address
- icache_read  out  1  request valid
- icache_addr  out  XLEN  request address, stable while icache_read=1 until icache_resp
- icache_resp  in  1  one-cycle response strobe
- icache_rdata  in  XLEN  instruction, valid with icache_resp
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  XLEN  PC of IF/ID instruction
- if_id_instr  out  XLEN  IF/ID instruction (32'h0000_0013 NOP when invalid)

Behaviour:
- Definitions:
  - advance = load_pc & if_id_load & ~stall_mem.
  - flush = redirect & ~stall_mem (redirect is ignored while stall_mem=1; EX re-asserts it).
- Reset (rst_n=0 at a clk edge):
  - pc = RESET_PC, state = FETCH.
  - if_id_valid = 0, if_id_pc = 0, if_id_instr = NOP.
  - Buffer cleared.
  - Reset mid-request abandons it; one stale icache_resp may follow and must be dropped (reset enters DISCARD_WAIT only if icache_read was 1 in the reset cycle, else FETCH).
- States: FETCH, HOLD, DISCARD_WAIT.
- FETCH: icache_read=1, icache_addr=pc.
  - flush & icache_resp: pc=redirect_pc, stay FETCH.
  - flush & ~icache_resp: pc=redirect_pc, go to DISCARD_WAIT.
  - ~flush & icache_resp & advance: IF/ID={1,pc,rdata}, pc=pc+4.
  - ~flush & icache_resp & ~advance: buf=rdata, go to HOLD.
  - ~flush & ~icache_resp & advance: IF/ID valid=0 (bubble).
- HOLD: icache_read=0.
  - flush: drop buffer, pc=redirect_pc, go to FETCH.
  - advance: IF/ID={1,pc,buf}, pc=pc+4, go to FETCH.
  - Otherwise hold.
- DISCARD_WAIT: icache_read=1 with the old address (held in a separate register, since icache_addr must stay stable).
  - On icache_resp: drop data, go to FETCH.
  - A further flush updates pc only.
- IF/ID register rules:
  - flush: valid=0 (overrides everything).
  - ~advance & ~flush: all fields hold.
  - Otherwise written as above.
- Latency: icache hit with resp in the request cycle gives one instruction per cycle.
- pc+4 wraps modulo 2^32.
- The low two bits of redirect_pc are forced to 0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_redirects[31:0].
  - perf_stall_cycles counts cycles with icache_read=1 & ~icache_resp.
  - perf_redirects counts flush cycles.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_types:
  - fetch_state_t enum (FETCH, HOLD, DISCARD_WAIT).
  - NOP_INSTR = 32'h0000_0013.
  - if_id_fields_t struct {valid, pc, instr}.
- One sub-module, fetch_hold_buf: single-entry buffer with load/clear/valid, used for HOLD.

Test Plan:
- Reset then icache_resp every cycle, no stalls -> if_id_pc sequence 0x60, 0x64, 0x68; if_id_valid=1 from the second cycle.
- Load-use stall: load_pc=0 for 1 cycle while resp for 0x64 arrives -> state HOLD, IF/ID holds 0x60; next cycle IF/ID={1,0x64,data}, icache_addr=0x68.
- Miss then redirect: resp delayed 3 cycles at 0x68, redirect to 0x200 in cycle 1 -> icache_addr stays 0x68 until resp, that data is never in IF/ID, next request is 0x200, if_id_valid=0 meanwhile.
- redirect with stall_mem=1 -> no flush and IF/ID unchanged; same redirect after stall_mem drops -> flush, pc=0x200.
- Simultaneous icache_resp and redirect (target 0x104) -> response dropped, icache_addr=0x104 next cycle, if_id_valid=0.
- Reset asserted during an outstanding request -> stale resp is dropped, first IF/ID pc=0x60; with FETCH_PERF_EN, counters read 0 after reset.
